shared_reg_arbiter: RTL and testbench

//  Round-robin arbiter/controller owning one shared W-bit D-flip-flop register bank (q).
//  N requesters compete for write access; the winner writes one word per clock

---
 rtl/shared_reg_arbiter_if.sv | 25 ++
 rtl/shared_reg_arbiter.sv | 131 +++++++++++++
 tb/tb_shared_reg_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/shared_reg_arbiter_if.sv
// Bus between the requesters and the shared-register arbiter.
// The arbiter takes the slave view; requester logic (or a bench) takes the master view.
interface shared_reg_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [OW-1:0]  owner;
  logic [W-1:0]   q;
  logic           q_valid;

  modport master (
    output req, wdata,
    input  gnt, owner, q, q_valid
  );

  modport slave (
    input  req, wdata,
    output gnt, owner, q, q_valid
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that owns one shared W-bit register.
// The granted requester writes one word per clock while it keeps req high, for at most
// MAX_HOLD words; ownership then rotates to the next requester in round-robin order
// without an idle bubble. q/q_valid feed downstream consumers.
module shared_reg_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  shared_reg_arbiter_if.slave bus
);

  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [W-1:0]  data_q, data_d;
  logic          q_valid_q, q_valid_d;

  logic          release_own;
  logic [OW-1:0] sel;
  logic [OW-1:0] next_ptr;

  // First requester found scanning start, start+1, ... wrapping modulo N.
  // Scanning backwards lets the lowest offset overwrite any later hit.
  function automatic logic [OW-1:0] rr_pick(input logic [N-1:0] r, input logic [OW-1:0] start);
    logic [OW-1:0] pick;
    logic [OW-1:0] idx;
    pick = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = OW'((int'(start) + k) % N);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  // Next-state logic: grant from IDLE, write/count/release while BUSY, and on release
  // re-arbitrate over the current requests in the same cycle starting after the owner.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    data_d      = data_q;
    q_valid_d   = 1'b0;
    release_own = 1'b0;
    sel         = '0;
    next_ptr    = (int'(owner_q) == N - 1) ? '0 : owner_q + OW'(1);

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          sel        = rr_pick(bus.req, ptr_q);
          gnt_d      = N'(1) << sel;
          owner_d    = sel;
          hold_cnt_d = '0;
          state_d    = BUSY;
        end
      end

      BUSY: begin
        if (bus.req[owner_q]) begin
          data_d     = bus.wdata[int'(owner_q)*W +: W];
          q_valid_d  = 1'b1;
          hold_cnt_d = hold_cnt_q + HW'(1);
          if (int'(hold_cnt_q) + 1 >= MAX_HOLD) release_own = 1'b1;
        end else begin
          release_own = 1'b1;
        end

        if (release_own) begin
          ptr_d = next_ptr;
          if (|bus.req) begin
            sel        = rr_pick(bus.req, next_ptr);
            gnt_d      = N'(1) << sel;
            owner_d    = sel;
            hold_cnt_d = '0;
          end else begin
            gnt_d      = '0;
            hold_cnt_d = '0;
            state_d    = IDLE;
          end
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything at once, dropping any write in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      data_q     <= '0;
      q_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      data_q     <= data_d;
      q_valid_q  <= q_valid_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.owner   = owner_q;
  assign bus.q       = data_q;
  assign bus.q_valid = q_valid_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (N=4, W=8, MAX_HOLD=4, 100 ns clock).
// Each scenario task drives its own stimulus and compares outputs 1 ns after the rising edge.
module tb_shared_reg_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] lane [4];
  int         checks = 0;
  int         failures = 0;

  shared_reg_arbiter_if #(.N(N), .W(W)) bus ();

  assign bus.wdata = {lane[3], lane[2], lane[1], lane[0]};

  shared_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 100 ns free-running clock
  always #50 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus.req = '0;
    for (int i = 0; i < 4; i++) lane[i] = 8'h00;
    rst = 1'b1;
    #20;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.req = 4'($urandom);
      for (int i = 0; i < 4; i++) lane[i] = 8'($urandom);
      tick();
      checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("[TB] FAIL reset_gnt cyc=%0d got=%b exp=0000", c, bus.gnt); end
      checks++; if (bus.q !== 8'h00) begin failures++; $display("[TB] FAIL reset_q cyc=%0d got=%h exp=00", c, bus.q); end
      checks++; if (bus.q_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_qvalid cyc=%0d got=%b exp=0", c, bus.q_valid); end
      checks++; if (bus.owner !== 2'd0) begin failures++; $display("[TB] FAIL reset_owner cyc=%0d got=%0d exp=0", c, bus.owner); end
    end
    rst = 1'b0;
    bus.req = '0;
  endtask

  task automatic test_single;
    logic [7:0] exp_q;
    logic       exp_v;
    do_reset();
    lane[0] = 8'hAA; lane[1] = 8'hBB; lane[3] = 8'hCC;
    bus.req = 4'b0100;
    for (int n = 0; n < 10; n++) begin
      lane[2] = 8'(8'h10 + n);
      tick();
      exp_v = (n != 0);
      exp_q = (n == 0) ? 8'h00 : 8'(8'h10 + n);
      checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("[TB] FAIL single_gnt edge=%0d got=%b exp=0100", n + 1, bus.gnt); end
      checks++; if (bus.owner !== 2'd2) begin failures++; $display("[TB] FAIL single_owner edge=%0d got=%0d exp=2", n + 1, bus.owner); end
      checks++; if (bus.q_valid !== exp_v) begin failures++; $display("[TB] FAIL single_qvalid edge=%0d got=%b exp=%b", n + 1, bus.q_valid, exp_v); end
      checks++; if (bus.q !== exp_q) begin failures++; $display("[TB] FAIL single_q edge=%0d got=%h exp=%h", n + 1, bus.q, exp_q); end
    end
  endtask

  task automatic test_all_req;
    logic [1:0] exp_owner;
    logic [3:0] exp_gnt;
    logic [7:0] exp_q;
    logic       exp_v;
    do_reset();
    for (int i = 0; i < 4; i++) lane[i] = 8'(8'hA0 + i);
    bus.req = 4'b1111;
    for (int e = 1; e <= 18; e++) begin
      tick();
      exp_owner = 2'(((e - 1) / 4) % 4);
      exp_gnt   = 4'b0001 << exp_owner;
      exp_v     = (e >= 2);
      exp_q     = (e >= 2) ? 8'(8'hA0 + ((e - 2) / 4) % 4) : 8'h00;
      checks++; if (bus.owner !== exp_owner) begin failures++; $display("[TB] FAIL rr_owner edge=%0d got=%0d exp=%0d", e, bus.owner, exp_owner); end
      checks++; if (bus.gnt !== exp_gnt) begin failures++; $display("[TB] FAIL rr_gnt edge=%0d got=%b exp=%b", e, bus.gnt, exp_gnt); end
      checks++; if (bus.q_valid !== exp_v) begin failures++; $display("[TB] FAIL rr_qvalid edge=%0d got=%b exp=%b", e, bus.q_valid, exp_v); end
      checks++; if (bus.q !== exp_q) begin failures++; $display("[TB] FAIL rr_q edge=%0d got=%h exp=%h", e, bus.q, exp_q); end
    end
  endtask

  task automatic test_early_drop;
    int pulses;
    do_reset();
    lane[0] = 8'h11; lane[1] = 8'h22;
    bus.req = 4'b0011;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("[TB] FAIL drop_first_gnt got=%b exp=0001", bus.gnt); end
    pulses = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (bus.q_valid === 1'b1 && bus.owner === 2'd0) pulses++;
      checks++; if (bus.q !== 8'h11) begin failures++; $display("[TB] FAIL drop_q0 write=%0d got=%h exp=11", k, bus.q); end
    end
    bus.req = 4'b0010;
    tick();
    if (bus.q_valid === 1'b1) pulses++;
    checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("[TB] FAIL drop_handover_gnt got=%b exp=0010", bus.gnt); end
    checks++; if (bus.owner !== 2'd1) begin failures++; $display("[TB] FAIL drop_handover_owner got=%0d exp=1", bus.owner); end
    checks++; if (bus.q_valid !== 1'b0) begin failures++; $display("[TB] FAIL drop_nowrite_qvalid got=%b exp=0", bus.q_valid); end
    checks++; if (bus.q !== 8'h11) begin failures++; $display("[TB] FAIL drop_hold_q got=%h exp=11", bus.q); end
    checks++; if (pulses !== 2) begin failures++; $display("[TB] FAIL drop_pulse_count got=%0d exp=2", pulses); end
    tick();
    checks++; if (bus.q !== 8'h22 || bus.q_valid !== 1'b1) begin failures++; $display("[TB] FAIL drop_next_write q=%h v=%b exp q=22 v=1", bus.q, bus.q_valid); end
  endtask

  task automatic test_wrap;
    do_reset();
    lane[3] = 8'h33; lane[0] = 8'h44;
    bus.req = 4'b1000;
    tick();
    checks++; if (bus.owner !== 2'd3 || bus.gnt !== 4'b1000) begin failures++; $display("[TB] FAIL wrap_grant3 owner=%0d gnt=%b exp owner=3 gnt=1000", bus.owner, bus.gnt); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.q !== 8'h33 || bus.q_valid !== 1'b1) begin failures++; $display("[TB] FAIL wrap_write3 n=%0d q=%h v=%b exp q=33 v=1", k, bus.q, bus.q_valid); end
    end
    bus.req = 4'b1001;
    tick();
    checks++; if (bus.q !== 8'h33 || bus.q_valid !== 1'b1) begin failures++; $display("[TB] FAIL wrap_last_write q=%h v=%b exp q=33 v=1", bus.q, bus.q_valid); end
    checks++; if (bus.owner !== 2'd0 || bus.gnt !== 4'b0001) begin failures++; $display("[TB] FAIL wrap_rotate owner=%0d gnt=%b exp owner=0 gnt=0001", bus.owner, bus.gnt); end
    bus.req = 4'b0001;
    tick();
    checks++; if (bus.q !== 8'h44 || bus.q_valid !== 1'b1) begin failures++; $display("[TB] FAIL wrap_write0 q=%h v=%b exp q=44 v=1", bus.q, bus.q_valid); end
  endtask

  task automatic test_midop_reset;
    int writes;
    do_reset();
    lane[1] = 8'h55; lane[0] = 8'h66;
    bus.req = 4'b0010;
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("[TB] FAIL mid_grant got=%b exp=0010", bus.gnt); end
    tick();
    checks++; if (bus.q !== 8'h55) begin failures++; $display("[TB] FAIL mid_first_write got=%h exp=55", bus.q); end
    #20;
    rst = 1'b1;
    lane[1] = 8'h77;
    #1;
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("[TB] FAIL mid_async_gnt got=%b exp=0000", bus.gnt); end
    checks++; if (bus.q !== 8'h00) begin failures++; $display("[TB] FAIL mid_async_q got=%h exp=00", bus.q); end
    checks++; if (bus.q_valid !== 1'b0 || bus.owner !== 2'd0) begin failures++; $display("[TB] FAIL mid_async_misc v=%b owner=%0d exp v=0 owner=0", bus.q_valid, bus.owner); end
    tick();
    checks++; if (bus.gnt !== 4'b0000 || bus.q !== 8'h00) begin failures++; $display("[TB] FAIL mid_held gnt=%b q=%h exp gnt=0000 q=00", bus.gnt, bus.q); end
    rst = 1'b0;
    tick();
    checks++; if (bus.gnt !== 4'b0010 || bus.owner !== 2'd1 || bus.q_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_regrant gnt=%b owner=%0d v=%b exp gnt=0010 owner=1 v=0", bus.gnt, bus.owner, bus.q_valid); end
    bus.req = 4'b0011;
    writes = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.q_valid === 1'b1) writes++;
      checks++; if (bus.q !== 8'h77) begin failures++; $display("[TB] FAIL mid_q n=%0d got=%h exp=77", k, bus.q); end
      if (k < 3) begin
        checks++; if (bus.owner !== 2'd1) begin failures++; $display("[TB] FAIL mid_hold_owner n=%0d got=%0d exp=1", k, bus.owner); end
      end else begin
        checks++; if (bus.owner !== 2'd0 || bus.gnt !== 4'b0001) begin failures++; $display("[TB] FAIL mid_rotate owner=%0d gnt=%b exp owner=0 gnt=0001", bus.owner, bus.gnt); end
      end
    end
    checks++; if (writes !== 4) begin failures++; $display("[TB] FAIL mid_write_count got=%0d exp=4", writes); end
  endtask

  initial begin
    bus.req = '0;
    for (int i = 0; i < 4; i++) lane[i] = 8'h00;
    test_reset();
    test_single();
    test_all_req();
    test_early_drop();
    test_wrap();
    test_midop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
